// File: rtl/deadlock_report_ctrl_if.sv
// Port bundle between the deadlock monitor / harness and deadlock_report_ctrl.
// The master side drives the monitor flags and control; the slave side returns status.
interface deadlock_report_ctrl_if #(
  parameter int INFO_W = 4,
  parameter int CNT_W  = 8
);
  logic              enable;
  logic              clear;
  logic              block;
  logic [INFO_W-1:0] axis_block_info;
  logic              deadlock_detected;
  logic              report_pulse;
  logic              finish_req;
  logic [INFO_W-1:0] latched_info;
  logic [CNT_W-1:0]  run_cnt;
  logic [CNT_W-1:0]  transient_cnt;

  modport master (
    output enable, clear, block, axis_block_info,
    input  deadlock_detected, report_pulse, finish_req, latched_info,
    input  run_cnt, transient_cnt
  );

  modport slave (
    input  enable, clear, block, axis_block_info,
    output deadlock_detected, report_pulse, finish_req, latched_info,
    output run_cnt, transient_cnt
  );
endinterface

// File: rtl/deadlock_report_ctrl.sv
// Debounces the monitor's block flag, declares a deadlock after THRESH consecutive
// blocked cycles, latches the channel pattern and counts transient block episodes.
module deadlock_report_ctrl #(
  parameter int THRESH = 16,
  parameter int INFO_W = 4,
  parameter int CNT_W  = 8
) (
  input logic                   clock,
  input logic                   reset,
  deadlock_report_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COUNT    = 2'd1,
    ST_REPORTED = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] THRESH_C    = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] THRESH_M1_C = CNT_W'(THRESH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX_C   = {CNT_W{1'b1}};

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  run_cnt_r, run_cnt_s;
  logic [CNT_W-1:0]  trans_cnt_r, trans_cnt_s;
  logic [INFO_W-1:0] info_r, info_s;
  logic              detected_r, detected_s;
  logic              pulse_r, pulse_s;
  logic              eb_s;

  assign eb_s = bus.block & bus.enable;

  // Next-state and next-output logic; every output is a register fed from here.
  always_comb begin
    state_s     = state_r;
    run_cnt_s   = run_cnt_r;
    trans_cnt_s = trans_cnt_r;
    info_s      = info_r;
    detected_s  = detected_r;
    pulse_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (eb_s) begin
          run_cnt_s = {{(CNT_W-1){1'b0}}, 1'b1};
          if (THRESH == 1) begin
            state_s    = ST_REPORTED;
            detected_s = 1'b1;
            pulse_s    = 1'b1;
            info_s     = bus.axis_block_info;
          end else begin
            state_s = ST_COUNT;
          end
        end else begin
          run_cnt_s = {CNT_W{1'b0}};
        end
      end
      ST_COUNT: begin
        if (eb_s && (run_cnt_r == THRESH_M1_C)) begin
          state_s    = ST_REPORTED;
          run_cnt_s  = THRESH_C;
          detected_s = 1'b1;
          pulse_s    = 1'b1;
          info_s     = bus.axis_block_info;
        end else if (eb_s) begin
          run_cnt_s = run_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          // Episode ended before the threshold: a transient, counted with saturation.
          state_s   = ST_IDLE;
          run_cnt_s = {CNT_W{1'b0}};
          if (trans_cnt_r != CNT_MAX_C) begin
            trans_cnt_s = trans_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            trans_cnt_s = trans_cnt_r;
          end
        end
      end
      ST_REPORTED: begin
        run_cnt_s = THRESH_C;
      end
      default: begin
        state_s   = ST_IDLE;
        run_cnt_s = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and output registers; clear behaves exactly like reset.
  always_ff @(posedge clock) begin
    if (reset || bus.clear) begin
      state_r     <= ST_IDLE;
      run_cnt_r   <= {CNT_W{1'b0}};
      trans_cnt_r <= {CNT_W{1'b0}};
      info_r      <= {INFO_W{1'b0}};
      detected_r  <= 1'b0;
      pulse_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      run_cnt_r   <= run_cnt_s;
      trans_cnt_r <= trans_cnt_s;
      info_r      <= info_s;
      detected_r  <= detected_s;
      pulse_r     <= pulse_s;
    end
  end

  assign bus.deadlock_detected = detected_r;
  assign bus.finish_req        = detected_r;
  assign bus.report_pulse      = pulse_r;
  assign bus.latched_info      = info_r;
  assign bus.run_cnt           = run_cnt_r;
  assign bus.transient_cnt     = trans_cnt_r;

endmodule

// File: tb/tb_deadlock_report_ctrl.sv
// Directed bench for deadlock_report_ctrl: one instance with THRESH=4, one with THRESH=1.
module tb_deadlock_report_ctrl;

  logic clock;
  logic reset;
  int   total_r;
  int   bad_r;

  deadlock_report_ctrl_if #(.INFO_W(4), .CNT_W(8)) a_if ();
  deadlock_report_ctrl_if #(.INFO_W(4), .CNT_W(8)) b_if ();

  deadlock_report_ctrl #(.THRESH(4), .INFO_W(4), .CNT_W(8)) u_dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (a_if)
  );

  deadlock_report_ctrl #(.THRESH(1), .INFO_W(4), .CNT_W(8)) u_dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (b_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_r++;
    if (got !== exp) begin
      bad_r++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check_a(input string tag, input logic det, input logic pulse,
                         input logic [3:0] info, input logic [7:0] run, input logic [7:0] trans);
    check_val({tag, ".det"},    32'(a_if.deadlock_detected), 32'(det));
    check_val({tag, ".finish"}, 32'(a_if.finish_req),        32'(det));
    check_val({tag, ".pulse"},  32'(a_if.report_pulse),      32'(pulse));
    check_val({tag, ".info"},   32'(a_if.latched_info),      32'(info));
    check_val({tag, ".run"},    32'(a_if.run_cnt),           32'(run));
    check_val({tag, ".trans"},  32'(a_if.transient_cnt),     32'(trans));
  endtask

  task automatic check_b(input string tag, input logic det, input logic pulse,
                         input logic [3:0] info, input logic [7:0] run, input logic [7:0] trans);
    check_val({tag, ".det"},    32'(b_if.deadlock_detected), 32'(det));
    check_val({tag, ".finish"}, 32'(b_if.finish_req),        32'(det));
    check_val({tag, ".pulse"},  32'(b_if.report_pulse),      32'(pulse));
    check_val({tag, ".info"},   32'(b_if.latched_info),      32'(info));
    check_val({tag, ".run"},    32'(b_if.run_cnt),           32'(run));
    check_val({tag, ".trans"},  32'(b_if.transient_cnt),     32'(trans));
  endtask

  task automatic clear_a();
    a_if.clear = 1'b1;
    a_if.block = 1'b0;
    step(1);
    a_if.clear = 1'b0;
  endtask

  initial begin
    total_r = 0;
    bad_r   = 0;
    reset   = 1'b1;
    a_if.enable = 1'b1; a_if.clear = 1'b0; a_if.block = 1'b0; a_if.axis_block_info = 4'h0;
    b_if.enable = 1'b0; b_if.clear = 1'b0; b_if.block = 1'b0; b_if.axis_block_info = 4'h0;
    step(2);
    reset = 1'b0;
    check_a("rst_a", 1'b0, 1'b0, 4'h0, 8'd0, 8'd0);
    check_b("rst_b", 1'b0, 1'b0, 4'h0, 8'd0, 8'd0);

    // 1: four blocked cycles declare a deadlock
    a_if.block = 1'b1; a_if.axis_block_info = 4'hE;
    for (int i = 1; i <= 3; i++) begin
      step(1);
      check_a($sformatf("t1_cnt%0d", i), 1'b0, 1'b0, 4'h0, 8'(i), 8'd0);
    end
    step(1);
    check_a("t1_decl", 1'b1, 1'b1, 4'hE, 8'd4, 8'd0);
    a_if.block = 1'b0;
    step(1);
    check_a("t1_hold", 1'b1, 1'b0, 4'hE, 8'd4, 8'd0);
    clear_a();
    check_a("t1_clr", 1'b0, 1'b0, 4'h0, 8'd0, 8'd0);

    // 2: transient episodes, then saturation at 255
    a_if.block = 1'b1;
    step(3);
    check_a("t2_run3", 1'b0, 1'b0, 4'h0, 8'd3, 8'd0);
    a_if.block = 1'b0;
    step(1);
    check_a("t2_tr1", 1'b0, 1'b0, 4'h0, 8'd0, 8'd1);
    for (int i = 0; i < 299; i++) begin
      a_if.block = 1'b1;
      step(3);
      a_if.block = 1'b0;
      step(1);
      if (i == 253) check_a("t2_tr255", 1'b0, 1'b0, 4'h0, 8'd0, 8'd255);
    end
    check_a("t2_sat", 1'b0, 1'b0, 4'h0, 8'd0, 8'd255);
    clear_a();
    check_a("t2_clr", 1'b0, 1'b0, 4'h0, 8'd0, 8'd0);

    // 3: info sampled only on the declaring cycle
    a_if.block = 1'b1; a_if.axis_block_info = 4'hE;
    step(3);
    a_if.axis_block_info = 4'hD;
    step(1);
    check_a("t3_decl", 1'b1, 1'b1, 4'hD, 8'd4, 8'd0);
    a_if.axis_block_info = 4'h5; a_if.block = 1'b0;
    step(1);
    check_a("t3_hold", 1'b1, 1'b0, 4'hD, 8'd4, 8'd0);
    a_if.enable = 1'b0; a_if.block = 1'b1; a_if.axis_block_info = 4'h3;
    step(2);
    check_a("t3_sticky", 1'b1, 1'b0, 4'hD, 8'd4, 8'd0);
    a_if.enable = 1'b1;
    clear_a();

    // 4: clear on the declaring cycle wins, then normal detection
    a_if.block = 1'b1; a_if.axis_block_info = 4'hE;
    step(3);
    a_if.clear = 1'b1;
    step(1);
    check_a("t4_clrwin", 1'b0, 1'b0, 4'h0, 8'd0, 8'd0);
    a_if.clear = 1'b0;
    step(3);
    check_a("t4_run3", 1'b0, 1'b0, 4'h0, 8'd3, 8'd0);
    step(1);
    check_a("t4_decl", 1'b1, 1'b1, 4'hE, 8'd4, 8'd0);
    clear_a();

    // 5: THRESH=1 instance
    b_if.enable = 1'b1; b_if.block = 1'b1; b_if.axis_block_info = 4'h9;
    step(1);
    check_b("t5_decl", 1'b1, 1'b1, 4'h9, 8'd1, 8'd0);
    b_if.block = 1'b0;
    step(1);
    check_b("t5_hold", 1'b1, 1'b0, 4'h9, 8'd1, 8'd0);
    b_if.clear = 1'b1;
    step(1);
    b_if.clear = 1'b0;
    check_b("t5_clr", 1'b0, 1'b0, 4'h0, 8'd0, 8'd0);
    b_if.enable = 1'b0; b_if.block = 1'b1;
    step(3);
    check_b("t5_dis", 1'b0, 1'b0, 4'h0, 8'd0, 8'd0);

    // enable dropping mid-COUNT ends a transient episode
    a_if.block = 1'b1;
    step(2);
    a_if.enable = 1'b0;
    step(1);
    check_a("t5_endis", 1'b0, 1'b0, 4'h0, 8'd0, 8'd1);
    a_if.enable = 1'b1; a_if.block = 1'b0;
    clear_a();

    // 6: reset in REPORTED and mid-COUNT
    a_if.block = 1'b1; a_if.axis_block_info = 4'h7;
    step(4);
    check_a("t6_decl", 1'b1, 1'b1, 4'h7, 8'd4, 8'd0);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check_a("t6_rst_rep", 1'b0, 1'b0, 4'h0, 8'd0, 8'd0);
    step(2);
    check_a("t6_run2", 1'b0, 1'b0, 4'h0, 8'd2, 8'd0);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    a_if.block = 1'b0;
    check_a("t6_rst_cnt", 1'b0, 1'b0, 4'h0, 8'd0, 8'd0);
    step(1);
    check_a("t6_after", 1'b0, 1'b0, 4'h0, 8'd0, 8'd0);

    $display("test done: total=%0d bad=%0d", total_r, bad_r);
    $finish;
  end

endmodule
